// File: rtl/conway_serial_pkg.sv
// Shared types for the Conway board serial link: transmitter FSM states and
// a helper that sizes the bit counter.
package conway_serial_pkg;

  typedef enum logic [0:0] {
    P2S_IDLE  = 1'b0,
    P2S_SHIFT = 1'b1
  } p2s_state_e;

  // Counter width for a DATA_SIZE-bit frame; never below 1 bit.
  function automatic int p2s_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/p2s_hold_buffer.sv
// One-entry holding register for the serial transmitter. It takes the next
// word while a frame is still shifting so frames can run without a gap.
module p2s_hold_buffer #(
  parameter int DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (push) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/parallel_to_serial.sv
// Parallel-to-serial transmitter, MSB first, valid/ready on both sides.
// Optional macro PARALLEL_TO_SERIAL_HOLD_BUFFER_EN adds a one-word holding register.
module parallel_to_serial
  import conway_serial_pkg::*;
#(
  parameter int DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] load_data,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic                 data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = p2s_cnt_w(DATA_SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_SIZE - 1);

  p2s_state_e           state;
  logic [DATA_SIZE-1:0] shreg;
  logic [CW-1:0]        count;
  logic                 load_beat;
  logic                 bit_beat;
  logic                 last_beat;

  assign out_valid = !rst && (state == P2S_SHIFT);
  assign busy      = out_valid;
  assign data_out  = out_valid && shreg[DATA_SIZE-1];
  assign load_beat = load_valid && load_ready;
  assign bit_beat  = out_valid && out_ready;
  assign last_beat = bit_beat && (count == '0);

`ifdef PARALLEL_TO_SERIAL_HOLD_BUFFER_EN
  logic                 hold_full;
  logic [DATA_SIZE-1:0] hold;
  logic                 hold_push;
  logic                 hold_pop;

  assign load_ready = !rst && !hold_full;
  // A load on the last beat with an empty hold bypasses straight into shreg.
  assign hold_push  = load_beat && (state == P2S_SHIFT) && !last_beat;
  assign hold_pop   = last_beat && hold_full;

  p2s_hold_buffer #(.DATA_SIZE(DATA_SIZE)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .push (hold_push),
    .pop  (hold_pop),
    .din  (load_data),
    .dout (hold),
    .full (hold_full)
  );
`else
  assign load_ready = !rst && (state == P2S_IDLE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= P2S_IDLE;
      shreg <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= last_beat;
      case (state)
        P2S_IDLE: begin
          if (load_beat) begin
            shreg <= load_data;
            count <= CNT_LAST;
            state <= P2S_SHIFT;
          end
        end
        P2S_SHIFT: begin
          if (bit_beat) begin
            if (count != '0) begin
              shreg <= {shreg[DATA_SIZE-2:0], 1'b0};
              count <= count - CW'(1);
            end else begin
`ifdef PARALLEL_TO_SERIAL_HOLD_BUFFER_EN
              if (hold_full) begin
                shreg <= hold;
                count <= CNT_LAST;
              end else if (load_beat) begin
                shreg <= load_data;
                count <= CNT_LAST;
              end else begin
                state <= P2S_IDLE;
              end
`else
              state <= P2S_IDLE;
`endif
            end
          end
        end
        default: state <= P2S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial: an 8-bit instance for frame timing
// and a 64-bit instance looped back into a serial_to_parallel model.
module tb_parallel_to_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic       data_out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  logic [63:0] load_data64;
  logic        load_valid64;
  logic        load_ready64;
  logic        data_out64;
  logic        out_valid64;
  logic        out_ready64;
  logic        busy64;
  logic        done64;
  logic [63:0] rx64;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  parallel_to_serial #(.DATA_SIZE(8)) dut (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  parallel_to_serial #(.DATA_SIZE(64)) dut64 (
    .clk(clk), .rst(rst), .load_data(load_data64), .load_valid(load_valid64),
    .load_ready(load_ready64), .data_out(data_out64), .out_valid(out_valid64),
    .out_ready(out_ready64), .busy(busy64), .done(done64)
  );

  // serial_to_parallel receiver model, enabled by out_valid & out_ready
  always @(posedge clk)
    if (rst) rx64 <= '0;
    else if (out_valid64 && out_ready64) rx64 <= {rx64[62:0], data_out64};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Load w, stall out_ready for stall_len cycles once bit stall_at is showing.
  task automatic run_frame(input logic [7:0] w, input int stall_at, input int stall_len);
    load_data = w; load_valid = 1'b1; out_ready = 1'b1;
    check("idle_load_ready", load_ready, 1);
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_bit", data_out, w[7-i]);
          check("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
      end
      check("bit", data_out, w[7-i]);
      check("bit_valid", out_valid, 1);
      check("bit_nodone", done, 0);
      tick();
    end
    check("done_pulse", done, 1);
    check("end_idle_valid", out_valid, 0);
    check("end_load_ready", load_ready, 1);
    tick();
    check("done_low", done, 0);
  endtask

  initial begin
    int nvalid, ndone, first_gap, last_valid, loads, cyc;
    logic [15:0] seq;
    logic        got;

    rst = 1'b1; load_data = '0; load_valid = 1'b0; out_ready = 1'b0;
    load_data64 = '0; load_valid64 = 1'b0; out_ready64 = 1'b0;
    #1;
    check("rst_load_ready", load_ready, 0);
    check("rst_valid", out_valid, 0);
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", data_out, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", load_ready, 1);

    // single frame and backpressure on bit 2
    run_frame(8'hA5, -1, 0);
    run_frame(8'hC3, 2, 5);

    // reset mid-frame after three bits of 8'hFF
    load_data = 8'hFF; load_valid = 1'b1; out_ready = 1'b1;
    tick();
    load_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("midrst_ready", load_ready, 0);
    check("midrst_valid_hi", out_valid, 0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", data_out, 0);
    check("midrst_done", done, 0);
    tick();
    check("midrst_done2", done, 0);
    run_frame(8'h01, -1, 0);

    // back-to-back with load_valid held high
    load_data = 8'h81; load_valid = 1'b1; out_ready = 1'b1;
    loads = 0; nvalid = 0; ndone = 0; first_gap = -1; last_valid = -1; seq = '0;
    if (load_ready) loads++;
    tick();
    load_data = 8'h7E;
    for (int c = 0; c < 19; c++) begin
      if (out_valid) begin
        seq = {seq[14:0], data_out};
        nvalid++;
        last_valid = c;
      end else if (first_gap < 0) begin
        first_gap = c;
      end
      if (done) ndone++;
      if (load_valid && load_ready) loads++;
      tick();
      if (loads == 2) load_valid = 1'b0;
    end
    check("b2b_seq", seq, 16'h817E);
    check("b2b_nvalid", nvalid, 16);
    check("b2b_ndone", ndone, 2);
`ifdef PARALLEL_TO_SERIAL_HOLD_BUFFER_EN
    check("b2b_first_gap", first_gap, 16);
    check("b2b_last_valid", last_valid, 15);
`else
    check("b2b_first_gap", first_gap, 8);
    check("b2b_last_valid", last_valid, 16);
`endif

`ifndef PARALLEL_TO_SERIAL_HOLD_BUFFER_EN
    // loads presented mid-frame must be ignored
    load_data = 8'h00; load_valid = 1'b1; out_ready = 1'b1;
    tick();
    load_data = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      load_valid = i[0];
      #1;
      check("busy_ignore_bit", data_out, 0);
      check("busy_ready_low", load_ready, 0);
      tick();
    end
    load_valid = 1'b0;
    #1;
    check("ignore_done", done, 1);
    check("ignore_ready_back", load_ready, 1);
    tick();
    check("ignore_no_reload", out_valid, 0);
`endif

    // 64-bit loopback with random backpressure
    load_data64 = 64'h0123_4567_89AB_CDEF; load_valid64 = 1'b1; out_ready64 = 1'b0;
    tick();
    load_valid64 = 1'b0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 2000) begin
      out_ready64 = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (done64) got = 1'b1;
    end
    check("loop_done_seen", got, 1);
    check("loop_word", rx64, 64'h0123_4567_89AB_CDEF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
